// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage elastic floating-point multiplier with pass-through tag
//
// Purpose:
//   Multiplies two operands in the {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}
//   format (exc: 00 zero, 01 normal, 10 inf, 11 NaN; no subnormals).
//   Three register stages with valid/ready handshake and full back-pressure.
//   An opaque tag travels with every operation; ordering is preserved.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid        operand pair present
//   in_ready        pair accepted this cycle (may depend on out_ready)
//   X, Y            operands
//   in_tag          tag carried with the pair
//   out_valid       result present
//   out_ready       consumer accepts the result
//   R               product
//   out_tag         tag belonging to R
//
// Pipeline:
//   S1  sign, biased exponent sum (WE+2 bits signed), significand product,
//       exception classification
//   S2  normalisation, guard/sticky extraction, rounding into {exp,frac}
//   S3  post-round range check and final packing

module fp_mul_pipe #(
    parameter int WE         = 7,
    parameter int WF         = 7,
    parameter int ROUND_MODE = 0,
    parameter int TAG_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WE+WF+2:0]     X,
    input  logic [WE+WF+2:0]     Y,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WE+WF+2:0]     R,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int N   = WE + WF + 3;
    localparam int EW  = WE + 2;          // signed exponent width inside the pipe
    localparam int PW  = 2 * WF + 2;      // significand product width
    localparam int EFW = EW + WF;         // joint {exp,frac} width for rounding

    localparam logic [EW-1:0] BIAS = EW'((1 << (WE - 1)) - 1);

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    // ------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its contents leave
    // this cycle. The chain is combinational back to in_ready.
    // ------------------------------------------------------------------
    logic v1_q, v2_q, v3_q;
    logic ready1, ready2, ready3;

    assign ready3   = out_ready | ~v3_q;
    assign ready2   = ~v2_q | ready3;
    assign ready1   = ~v1_q | ready2;
    assign in_ready = ready1;

    // ------------------------------------------------------------------
    // Stage 1: field extraction, classification, exponent sum, product
    // ------------------------------------------------------------------
    logic [1:0]    xe, ye;
    logic          xs, ys;
    logic [WE-1:0] xexp, yexp;
    logic [WF-1:0] xf, yf;

    assign xe   = X[N-1 -: 2];
    assign ye   = Y[N-1 -: 2];
    assign xs   = X[N-3];
    assign ys   = Y[N-3];
    assign xexp = X[WF +: WE];
    assign yexp = Y[WF +: WE];
    assign xf   = X[WF-1:0];
    assign yf   = Y[WF-1:0];

    logic [1:0]    s1_exc_d;
    logic          s1_sign_d;
    logic [EW-1:0] s1_exp_d;
    logic [PW-1:0] s1_prod_d;

    // Priority order matters: NaN beats everything, zero*inf is NaN,
    // then inf, then zero, leaving normal*normal.
    always_comb begin
        s1_exc_d = EXC_NORM;
        if (xe == EXC_NAN || ye == EXC_NAN) begin
            s1_exc_d = EXC_NAN;
        end else if ((xe == EXC_ZERO && ye == EXC_INF) ||
                     (xe == EXC_INF  && ye == EXC_ZERO)) begin
            s1_exc_d = EXC_NAN;
        end else if (xe == EXC_INF || ye == EXC_INF) begin
            s1_exc_d = EXC_INF;
        end else if (xe == EXC_ZERO || ye == EXC_ZERO) begin
            s1_exc_d = EXC_ZERO;
        end
    end

    assign s1_sign_d = xs ^ ys;
    // Two extra bits keep both underflow (negative) and overflow visible.
    assign s1_exp_d  = {2'b00, xexp} + {2'b00, yexp} - BIAS;
    assign s1_prod_d = PW'({1'b1, xf}) * PW'({1'b1, yf});

    logic [1:0]       s1_exc_q;
    logic             s1_sign_q;
    logic [EW-1:0]    s1_exp_q;
    logic [PW-1:0]    s1_prod_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_exc_q  <= '0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_prod_q <= '0;
            s1_tag_q  <= '0;
        end else if (ready1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_exc_q  <= s1_exc_d;
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= s1_exp_d;
                s1_prod_q <= s1_prod_d;
                s1_tag_q  <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise and round
    // ------------------------------------------------------------------
    logic          norm;
    logic [PW-2:0] aligned;
    logic [WF-1:0] frac_t;
    logic          guard_b;
    logic          sticky_b;
    logic          round_up;
    logic [EW-1:0] exp_n;
    logic [EFW-1:0] s2_ef_d;

    // Product lies in [1,4). The hidden bit is dropped here, so 'aligned'
    // holds only the bits after the leading one, left-justified.
    assign norm     = s1_prod_q[PW-1];
    assign aligned  = norm ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};
    assign frac_t   = aligned[PW-2 -: WF];
    assign guard_b  = aligned[WF];
    assign sticky_b = |aligned[WF-1:0];
    assign exp_n    = s1_exp_q + {{(EW-1){1'b0}}, norm};

    assign round_up = (ROUND_MODE == 0) ? (guard_b & (sticky_b | frac_t[0])) : 1'b0;

    // A carry out of the fraction lands in the exponent, which is exactly
    // the renormalisation needed when the fraction rounds up to 2.0.
    assign s2_ef_d = {exp_n, frac_t} + {{(EFW-1){1'b0}}, round_up};

    logic [1:0]       s2_exc_q;
    logic             s2_sign_q;
    logic [EFW-1:0]   s2_ef_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q      <= 1'b0;
            s2_exc_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_ef_q   <= '0;
            s2_tag_q  <= '0;
        end else if (ready2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_exc_q  <= s1_exc_q;
                s2_sign_q <= s1_sign_q;
                s2_ef_q   <= s2_ef_d;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: range check and packing
    // ------------------------------------------------------------------
    logic [EW-1:0] e3;
    logic [WF-1:0] f3;
    logic          under;
    logic          over;
    logic [N-1:0]  r3_d;

    assign e3    = s2_ef_q[EFW-1 -: EW];
    assign f3    = s2_ef_q[WF-1:0];
    assign under = e3[EW-1];
    // Non-negative values above 2^WE-1 have bit WE set.
    assign over  = ~e3[EW-1] & e3[EW-2];

    // Non-normal results carry zero exp/frac but keep the product sign.
    always_comb begin
        r3_d        = '0;
        r3_d[N-3]   = s2_sign_q;
        if (s2_exc_q == EXC_NORM) begin
            if (under) begin
                r3_d[N-1 -: 2] = EXC_ZERO;
            end else if (over) begin
                r3_d[N-1 -: 2] = EXC_INF;
            end else begin
                r3_d[N-1 -: 2] = EXC_NORM;
                r3_d[WF +: WE] = e3[WE-1:0];
                r3_d[WF-1:0]   = f3;
            end
        end else begin
            r3_d[N-1 -: 2] = s2_exc_q;
        end
    end

    logic [N-1:0]     r_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q  <= 1'b0;
            r_q   <= '0;
            tag_q <= '0;
        end else if (ready3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                r_q   <= r3_d;
                tag_q <= s2_tag_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign R         = r_q;
    assign out_tag   = tag_q;

endmodule
